// File: rtl/sdram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter_if
//   Bundle between the port arbiter and sdram_ctrl. It carries one write
//   request/ack pair and one read request/ack pair, each with a burst start
//   address and a burst length.
//
//   master : arbiter side. Drives the reqs, addrs and lens, receives the acks.
//   slave  : sdram_ctrl side. Receives the reqs, addrs and lens, drives the acks.
// ---------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 10
);
   logic              sdram_wr_req;
   logic              sdram_rd_req;
   logic              sdram_wr_ack;
   logic              sdram_rd_ack;
   logic [ADDR_W-1:0] sdram_wr_addr;
   logic [ADDR_W-1:0] sdram_rd_addr;
   logic [LEN_W-1:0]  wr_burst_len;
   logic [LEN_W-1:0]  rd_burst_len;

   modport master (
      output sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
             wr_burst_len, rd_burst_len,
      input  sdram_wr_ack, sdram_rd_ack
   );

   modport slave (
      input  sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
             wr_burst_len, rd_burst_len,
      output sdram_wr_ack, sdram_rd_ack
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//   Round-robin arbiter and address generator for NUM_CH FIFO channels in
//   front of sdram_ctrl. Each channel is either a write or a read channel,
//   selected by CH_IS_RD. Each channel walks its own [b_addr, e_addr) window
//   in steps of burst_len and has an optional ping-pong page, which is
//   inserted at address bit PP_BIT. Only one burst is in flight at a time.
//
//   sys_clk, sys_rst   : clock, synchronous active-high reset
//   init_end           : SDRAM initialisation done. Gates new grants.
//   ch_req / ch_rst    : per-channel burst request / address reset (levels)
//   ch_b_addr/e_addr   : per-channel window, flattened, channel 0 in the LSBs
//   ch_burst_len       : per-channel burst length, flattened
//   pingpang_en        : per-channel ping-pong enable
//   ch_grant / ch_done : one-hot grant for the burst / 1-cycle completion pulse
//   ch_page            : current ping-pong page of each channel
//   cur_ch             : index of the granted channel, for the data mux
//   sdram              : request/ack/address/length bundle to sdram_ctrl
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
   parameter int                NUM_CH   = 4,
   parameter logic [NUM_CH-1:0] CH_IS_RD = 4'b1100,
   parameter int                ADDR_W   = 24,
   parameter int                LEN_W    = 10,
   parameter int                PP_BIT   = 22,
   parameter int                CH_W     = $clog2(NUM_CH)
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     init_end,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_rst,
   input  logic [NUM_CH*ADDR_W-1:0] ch_b_addr,
   input  logic [NUM_CH*ADDR_W-1:0] ch_e_addr,
   input  logic [NUM_CH*LEN_W-1:0]  ch_burst_len,
   input  logic [NUM_CH-1:0]        pingpang_en,
   output logic [NUM_CH-1:0]        ch_grant,
   output logic [NUM_CH-1:0]        ch_done,
   output logic [NUM_CH-1:0]        ch_page,
   output logic [CH_W-1:0]          cur_ch,
   sdram_port_arbiter_if.master     sdram
);

   typedef enum logic [2:0] {IDLE, ARB, REQ, XFER, DONE} state_t;

   state_t              state_reg, state_next;
   logic [CH_W-1:0]     ptr_reg;
   logic [CH_W-1:0]     cur_ch_reg;
   logic                cur_rd_reg;
   logic [NUM_CH-1:0]   grant_reg;
   logic [NUM_CH-1:0]   done_reg;
   logic                wr_req_reg, rd_req_reg;
   logic [ADDR_W-1:0]   wr_addr_reg, rd_addr_reg;
   logic [LEN_W-1:0]    wr_len_reg, rd_len_reg;
   logic                loaded_reg;

   logic [NUM_CH-1:0]        eligible;
   logic                     pick_valid;
   logic [CH_W-1:0]          pick_idx;
   logic                     cur_ack;
   logic [NUM_CH*ADDR_W-1:0] out_addr_flat;
   logic [ADDR_W-1:0]        sel_addr;
   logic [LEN_W-1:0]         sel_len;

   // A channel held in address reset is never granted.
   assign eligible = ch_req & ~ch_rst;
   assign cur_ack  = cur_rd_reg ? sdram.sdram_rd_ack : sdram.sdram_wr_ack;
   assign sel_addr = out_addr_flat[pick_idx*ADDR_W +: ADDR_W];
   assign sel_len  = ch_burst_len[pick_idx*LEN_W +: LEN_W];

   // The round-robin search starts at the priority pointer. The first
   // eligible channel in rotating order wins.
   always_comb begin
      logic [CH_W:0] cand;
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, ptr_reg} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(NUM_CH))
            cand = cand - (CH_W+1)'(NUM_CH);
         if (!pick_valid && eligible[cand[CH_W-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[CH_W-1:0];
         end
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (init_end && (ch_req != '0)) state_next = ARB;
         ARB:     state_next = pick_valid ? REQ : IDLE;
         REQ:     if (cur_ack)  state_next = XFER;
         XFER:    if (!cur_ack) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- grant / request datapath ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ptr_reg     <= '0;
         cur_ch_reg  <= '0;
         cur_rd_reg  <= 1'b0;
         grant_reg   <= '0;
         done_reg    <= '0;
         wr_req_reg  <= 1'b0;
         rd_req_reg  <= 1'b0;
         wr_addr_reg <= '0;
         rd_addr_reg <= '0;
         wr_len_reg  <= '0;
         rd_len_reg  <= '0;
      end else begin
         done_reg <= '0;
         if (state_reg == ARB && pick_valid) begin
            cur_ch_reg <= pick_idx;
            cur_rd_reg <= CH_IS_RD[pick_idx];
            grant_reg  <= NUM_CH'(1) << pick_idx;
            ptr_reg    <= (pick_idx == CH_W'(NUM_CH-1)) ? '0 : pick_idx + 1'b1;
            if (CH_IS_RD[pick_idx]) begin
               rd_req_reg  <= 1'b1;
               rd_addr_reg <= sel_addr;
               rd_len_reg  <= sel_len;
            end else begin
               wr_req_reg  <= 1'b1;
               wr_addr_reg <= sel_addr;
               wr_len_reg  <= sel_len;
            end
         end
         if (state_reg == REQ && cur_ack) begin
            wr_req_reg <= 1'b0;
            rd_req_reg <= 1'b0;
         end
         // The grant drops when DONE is entered. done_reg mirrors the grant
         // for exactly that one cycle.
         if (state_reg == XFER && !cur_ack) begin
            grant_reg <= '0;
            done_reg  <= grant_reg;
         end
      end
   end

   // After reset, every channel copies its begin address once.
   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         loaded_reg <= 1'b0;
      else
         loaded_reg <= 1'b1;
   end

   // ---------------- per-channel address / page state ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [ADDR_W-1:0] addr_reg;
         logic              page_reg;
         logic              pp_en_reg;
         logic              rst_pend_reg;
         logic [ADDR_W-1:0] b_addr, e_addr, pp_addr;
         logic [LEN_W-1:0]  len;
         logic [ADDR_W+1:0] next_addr, span_end;
         logic              wrap, done_here;

         assign b_addr    = ch_b_addr[gi*ADDR_W +: ADDR_W];
         assign e_addr    = ch_e_addr[gi*ADDR_W +: ADDR_W];
         assign len       = ch_burst_len[gi*LEN_W +: LEN_W];
         // Two spare bits keep next + len from overflowing before the compare.
         assign next_addr = {2'b00, addr_reg} + {{(ADDR_W+2-LEN_W){1'b0}}, len};
         assign span_end  = next_addr + {{(ADDR_W+2-LEN_W){1'b0}}, len};
         assign wrap      = span_end > {2'b00, e_addr};
         assign done_here = (state_reg == DONE) && (cur_ch_reg == CH_W'(gi));

         always_comb begin
            pp_addr         = addr_reg;
            pp_addr[PP_BIT] = page_reg;
         end

         assign out_addr_flat[gi*ADDR_W +: ADDR_W] = pp_en_reg ? pp_addr : addr_reg;
         assign ch_page[gi] = page_reg;

         // A reset that arrives while the channel is granted is held pending,
         // so a short pulse during the burst still rewinds the channel in DONE.
         // At that point it takes priority over the normal wrap.
         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               addr_reg     <= '0;
               page_reg     <= 1'b0;
               pp_en_reg    <= 1'b0;
               rst_pend_reg <= 1'b0;
            end else if (!loaded_reg) begin
               addr_reg  <= b_addr;
               page_reg  <= 1'b0;
               pp_en_reg <= pingpang_en[gi];
            end else if (done_here) begin
               rst_pend_reg <= 1'b0;
               if (ch_rst[gi] || rst_pend_reg) begin
                  addr_reg  <= b_addr;
                  page_reg  <= 1'b0;
                  pp_en_reg <= pingpang_en[gi];
               end else if (wrap) begin
                  addr_reg  <= b_addr;
                  pp_en_reg <= pingpang_en[gi];
                  if (pingpang_en[gi])
                     page_reg <= ~page_reg;
               end else begin
                  addr_reg <= next_addr[ADDR_W-1:0];
               end
            end else if (ch_rst[gi]) begin
               if (grant_reg[gi]) begin
                  rst_pend_reg <= 1'b1;
               end else begin
                  addr_reg  <= b_addr;
                  page_reg  <= 1'b0;
                  pp_en_reg <= pingpang_en[gi];
               end
            end
         end
      end
   endgenerate

   assign ch_grant            = grant_reg;
   assign ch_done             = done_reg;
   assign cur_ch              = cur_ch_reg;
   assign sdram.sdram_wr_req  = wr_req_reg;
   assign sdram.sdram_rd_req  = rd_req_reg;
   assign sdram.sdram_wr_addr = wr_addr_reg;
   assign sdram.sdram_rd_addr = rd_addr_reg;
   assign sdram.wr_burst_len  = wr_len_reg;
   assign sdram.rd_burst_len  = rd_len_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
//   Self-checking bench for sdram_port_arbiter (4 channels, ch2/ch3 read).
//   Each test task pushes its expected bursts into a scoreboard queue.
//   serve() plays the sdram_ctrl role for one burst and reports what the DUT
//   showed. The test task pops the expectation and compares it inline.
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;
   localparam int NUM_CH = 4;
   localparam int ADDR_W = 24;
   localparam int LEN_W  = 10;

   typedef struct {
      int                ch;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      bit                rd;
   } exp_t;

   typedef struct {
      bit                ok;
      int                ch;
      logic [3:0]        gnt;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      bit                rd;
      bit                both;
      bit                req_after;
      int                gap;
      logic [3:0]        done_vec;
   } obs_t;

   logic                     clk = 1'b0;
   logic                     sys_rst = 1'b1;
   logic                     init_end = 1'b0;
   logic [NUM_CH-1:0]        ch_req = '0;
   logic [NUM_CH-1:0]        ch_rst = '0;
   logic [NUM_CH*ADDR_W-1:0] b_flat = '0;
   logic [NUM_CH*ADDR_W-1:0] e_flat = '0;
   logic [NUM_CH*LEN_W-1:0]  len_flat = '0;
   logic [NUM_CH-1:0]        pp_en = '0;
   logic [NUM_CH-1:0]        ch_grant, ch_done, ch_page;
   logic [1:0]               cur_ch;
   logic [3:0]               rd_mask = 4'b1100;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) sif ();

   sdram_port_arbiter #(
      .NUM_CH(NUM_CH), .CH_IS_RD(4'b1100), .ADDR_W(ADDR_W),
      .LEN_W(LEN_W), .PP_BIT(22)
   ) dut (
      .sys_clk(clk), .sys_rst(sys_rst), .init_end(init_end),
      .ch_req(ch_req), .ch_rst(ch_rst), .ch_b_addr(b_flat),
      .ch_e_addr(e_flat), .ch_burst_len(len_flat), .pingpang_en(pp_en),
      .ch_grant(ch_grant), .ch_done(ch_done), .ch_page(ch_page),
      .cur_ch(cur_ch), .sdram(sif)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic set_cfg(input int k, input logic [ADDR_W-1:0] b,
                          input logic [ADDR_W-1:0] e, input logic [LEN_W-1:0] len,
                          input bit pp);
      b_flat[k*ADDR_W +: ADDR_W] = b;
      e_flat[k*ADDR_W +: ADDR_W] = e;
      len_flat[k*LEN_W +: LEN_W] = len;
      pp_en[k]                   = pp;
   endtask

   task automatic do_reset();
      @(negedge clk);
      sys_rst = 1'b1;
      ch_req = '0;
      ch_rst = '0;
      sif.sdram_wr_ack = 1'b0;
      sif.sdram_rd_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sys_rst = 1'b0;
   endtask

   // Plays sdram_ctrl for one burst: waits for a request (bounded), acks it
   // for n_ack cycles, optionally pulses ch_rst during XFER, then times
   // ch_done relative to the ack falling.
   task automatic serve(input int n_ack, input logic [3:0] rst_pulse, output obs_t o);
      int w;
      o.ok = 1'b0; o.ch = 0; o.gnt = '0; o.addr = '0; o.len = '0; o.rd = 1'b0;
      o.both = 1'b0; o.req_after = 1'b0; o.gap = 0; o.done_vec = '0;
      w = 0;
      @(negedge clk);
      while (!(sif.sdram_wr_req || sif.sdram_rd_req) && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) return;
      o.ok   = 1'b1;
      o.ch   = int'(cur_ch);
      o.gnt  = ch_grant;
      o.rd   = sif.sdram_rd_req;
      o.both = sif.sdram_wr_req && sif.sdram_rd_req;
      o.addr = o.rd ? sif.sdram_rd_addr : sif.sdram_wr_addr;
      o.len  = o.rd ? sif.rd_burst_len : sif.wr_burst_len;
      if (o.rd) sif.sdram_rd_ack = 1'b1; else sif.sdram_wr_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      o.req_after = sif.sdram_wr_req || sif.sdram_rd_req;
      ch_rst = rst_pulse;
      for (int c = 1; c < n_ack; c++) begin
         @(posedge clk); @(negedge clk);
         ch_rst = '0;
      end
      sif.sdram_wr_ack = 1'b0;
      sif.sdram_rd_ack = 1'b0;
      ch_rst = '0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); @(negedge clk);
         o.gap++;
         if (ch_done != '0) begin
            o.done_vec = ch_done;
            break;
         end
      end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (ch_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", ch_grant); end
      n_checks++; if (ch_done !== 4'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", ch_done); end
      n_checks++; if (ch_page !== 4'b0) begin n_fail++; $display("FAIL reset_page: got %b expected 0000", ch_page); end
      n_checks++; if (cur_ch !== 2'd0) begin n_fail++; $display("FAIL reset_cur_ch: got %0d expected 0", cur_ch); end
      n_checks++; if ({sif.sdram_wr_req, sif.sdram_rd_req} !== 2'b00) begin n_fail++; $display("FAIL reset_reqs: got %b%b expected 00", sif.sdram_wr_req, sif.sdram_rd_req); end
      n_checks++; if ({sif.sdram_wr_addr, sif.sdram_rd_addr, sif.wr_burst_len, sif.rd_burst_len} !== '0) begin
         n_fail++; $display("FAIL reset_addr_len: got wr %0h rd %0h wl %0h rl %0h expected all 0",
                            sif.sdram_wr_addr, sif.sdram_rd_addr, sif.wr_burst_len, sif.rd_burst_len);
      end
   endtask

   task automatic test_round_robin();
      obs_t o;
      exp_t e;
      for (int k = 0; k < 4; k++)
         set_cfg(k, ADDR_W'(k*'h1000), ADDR_W'(k*'h1000 + 'h800), LEN_W'(16 + k), 1'b0);
      init_end = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         e.ch   = i % 4;
         e.len  = LEN_W'(16 + e.ch);
         e.addr = ADDR_W'(e.ch*'h1000 + (i/4)*(16 + e.ch));
         e.rd   = rd_mask[e.ch];
         sb_q.push_back(e);
      end
      ch_req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         serve(2, 4'b0, o);
         e = sb_q.pop_front();
         n_checks++; if (!o.ok) begin n_fail++; $display("FAIL rr_timeout[%0d]: got no request expected channel %0d", i, e.ch); continue; end
         n_checks++; if (o.ch !== e.ch || o.gnt !== 4'(1 << e.ch)) begin n_fail++; $display("FAIL rr_grant[%0d]: got ch %0d grant %b expected ch %0d", i, o.ch, o.gnt, e.ch); end
         n_checks++; if (o.rd !== e.rd || o.both) begin n_fail++; $display("FAIL rr_dir[%0d]: got rd %0b both %0b expected rd %0b", i, o.rd, o.both, e.rd); end
         n_checks++; if (o.addr !== e.addr || o.len !== e.len) begin n_fail++; $display("FAIL rr_addr[%0d]: got %0h/%0d expected %0h/%0d", i, o.addr, o.len, e.addr, e.len); end
         n_checks++; if (o.req_after || o.gap !== 1 || o.done_vec !== 4'(1 << e.ch)) begin
            n_fail++; $display("FAIL rr_done[%0d]: got req_after %0b gap %0d done %b expected 0/1/one-hot %0d", i, o.req_after, o.gap, o.done_vec, e.ch);
         end
      end
      ch_req = '0;
   endtask

   task automatic test_pingpong();
      obs_t o;
      exp_t e;
      logic [ADDR_W-1:0] m_addr;
      bit m_page;
      bit exp_page[6];
      set_cfg(0, 24'd0, 24'd1024, 10'd256, 1'b1);
      do_reset();
      m_addr = '0; m_page = 1'b0;
      for (int i = 0; i < 6; i++) begin
         e.ch = 0; e.len = 10'd256; e.rd = 1'b0;
         e.addr = m_page ? (m_addr | 24'h400000) : m_addr;
         sb_q.push_back(e);
         if (m_addr + 2*256 > 1024) begin m_addr = '0; m_page = ~m_page; end
         else m_addr = m_addr + 256;
         exp_page[i] = m_page;
      end
      ch_req = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         serve(1, 4'b0, o);
         e = sb_q.pop_front();
         n_checks++; if (!o.ok || o.addr !== e.addr) begin n_fail++; $display("FAIL pp_addr[%0d]: got %0h (ok %0b) expected %0h", i, o.addr, o.ok, e.addr); end
         @(negedge clk);
         n_checks++; if (ch_page[0] !== exp_page[i]) begin n_fail++; $display("FAIL pp_page[%0d]: got %0b expected %0b", i, ch_page[0], exp_page[i]); end
      end
      ch_req = '0;
   endtask

   task automatic test_ch_rst();
      obs_t o;
      exp_t e;
      int seen;
      logic [ADDR_W-1:0] addrs[4] = '{24'd0, 24'd256, 24'd512, 24'd0};
      set_cfg(1, 24'd0, 24'h1000, 10'd256, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         e.ch = 1; e.addr = addrs[i]; e.len = 10'd256; e.rd = 1'b0;
         sb_q.push_back(e);
      end
      ch_req = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         serve(4, (i == 2) ? 4'b0010 : 4'b0000, o);
         e = sb_q.pop_front();
         n_checks++; if (!o.ok || o.addr !== e.addr || o.done_vec !== 4'b0010) begin
            n_fail++; $display("FAIL rst_burst[%0d]: got addr %0h done %b (ok %0b) expected %0h/0010", i, o.addr, o.done_vec, o.ok, e.addr);
         end
      end
      n_checks++; if (ch_page[1] !== 1'b0) begin n_fail++; $display("FAIL rst_page: got %0b expected 0", ch_page[1]); end
      // A held ch_rst must block the grant.
      ch_rst = 4'b0010;
      seen = 0;
      repeat (20) begin @(negedge clk); if (sif.sdram_wr_req || ch_grant != '0) seen++; end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_blocks_grant: got %0d busy cycles expected 0", seen); end
      ch_rst = '0;
      ch_req = '0;
   endtask

   task automatic test_init_end();
      obs_t o;
      exp_t e;
      int seen;
      set_cfg(0, 24'h123, 24'h2000, 10'd8, 1'b0);
      init_end = 1'b0;
      do_reset();
      e.ch = 0; e.addr = 24'h123; e.len = 10'd8; e.rd = 1'b0;
      sb_q.push_back(e);
      ch_req = 4'b0001;
      seen = 0;
      repeat (50) begin @(negedge clk); if (sif.sdram_wr_req || sif.sdram_rd_req) seen++; end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL init_gate: got %0d request cycles expected 0", seen); end
      init_end = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++; if (sif.sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL init_lat1: got %0b expected 0", sif.sdram_wr_req); end
      @(posedge clk); @(negedge clk);
      e = sb_q.pop_front();
      n_checks++; if (sif.sdram_wr_req !== 1'b1 || sif.sdram_wr_addr !== e.addr || sif.wr_burst_len !== e.len) begin
         n_fail++; $display("FAIL init_lat2: got req %0b addr %0h len %0d expected 1/%0h/%0d", sif.sdram_wr_req, sif.sdram_wr_addr, sif.wr_burst_len, e.addr, e.len);
      end
      serve(1, 4'b0, o);
      n_checks++; if (!o.ok || o.gap !== 1) begin n_fail++; $display("FAIL init_done: got ok %0b gap %0d expected 1/1", o.ok, o.gap); end
      ch_req = '0;
   endtask

   task automatic test_ack_len();
      obs_t o;
      exp_t e;
      int lens[2] = '{1, 256};
      set_cfg(0, 24'd0, 24'h10000, 10'd256, 1'b0);
      do_reset();
      for (int i = 0; i < 2; i++) begin
         e.ch = 0; e.addr = ADDR_W'(i*256); e.len = 10'd256; e.rd = 1'b0;
         sb_q.push_back(e);
      end
      ch_req = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         serve(lens[i], 4'b0, o);
         e = sb_q.pop_front();
         n_checks++; if (!o.ok || o.addr !== e.addr) begin n_fail++; $display("FAIL ack_addr[%0d]: got %0h (ok %0b) expected %0h", i, o.addr, o.ok, e.addr); end
         n_checks++; if (o.req_after !== 1'b0 || o.gap !== 1 || o.done_vec !== 4'b0001) begin
            n_fail++; $display("FAIL ack_timing[%0d]: got req_after %0b gap %0d done %b expected 0/1/0001", i, o.req_after, o.gap, o.done_vec);
         end
      end
      ch_req = '0;
   endtask

   task automatic test_rst_mid_xfer();
      int w;
      int seen;
      set_cfg(2, 24'h300, 24'h1000, 10'd32, 1'b0);
      do_reset();
      ch_req = 4'b0100;
      w = 0;
      @(negedge clk);
      while (!sif.sdram_rd_req && w < 100) begin @(negedge clk); w++; end
      n_checks++; if (!sif.sdram_rd_req || sif.sdram_rd_addr !== 24'h300) begin
         n_fail++; $display("FAIL xrst_req: got rd_req %0b addr %0h expected 1/300", sif.sdram_rd_req, sif.sdram_rd_addr);
      end
      sif.sdram_rd_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      sys_rst = 1'b1;
      ch_req = '0;
      @(posedge clk); @(negedge clk);
      n_checks++; if ({ch_grant, ch_done, ch_page, cur_ch, sif.sdram_wr_req, sif.sdram_rd_req} !== '0 ||
                      {sif.sdram_wr_addr, sif.sdram_rd_addr, sif.wr_burst_len, sif.rd_burst_len} !== '0) begin
         n_fail++; $display("FAIL xrst_outputs: got grant %b done %b rd_req %0b rd_addr %0h rd_len %0d expected all 0",
                            ch_grant, ch_done, sif.sdram_rd_req, sif.sdram_rd_addr, sif.rd_burst_len);
      end
      sys_rst = 1'b0;
      seen = 0;
      repeat (5) begin @(negedge clk); if (sif.sdram_wr_req || sif.sdram_rd_req || ch_done != '0 || ch_grant != '0) seen++; end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL xrst_stale_ack: got %0d active cycles expected 0", seen); end
      sif.sdram_rd_ack = 1'b0;
   endtask

   initial begin
      sif.sdram_wr_ack = 1'b0;
      sif.sdram_rd_ack = 1'b0;
      test_reset();
      test_round_robin();
      test_pingpong();
      test_ch_rst();
      test_init_end();
      test_ack_len();
      test_rst_mid_xfer();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
